// File: rtl/multi_seq_ctrl_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM encoding,
// step-counter width and the default operand width.
package multi_seq_ctrl_pkg;

  localparam int CNT_W     = 3;
  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/multi_shift_add.sv
// Shift-add datapath: operand registers, accumulator and the partial-product
// adder. One multiplier bit is consumed per cycle while cnt_i is non-zero.
module multi_shift_add
  import multi_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [CNT_W-1:0]     cnt_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   sum_o
);

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;
  logic [CNT_W-1:0]   idx;
  logic [WIDTH-1:0]   b_sh;

  // cnt is 1-based, so bit step n examines B bit n-1 and A shifted by n-1
  always_comb begin
    idx    = cnt_i - CNT_W'(1);
    b_sh   = b_q >> idx;
    addend = '0;
    if (cnt_i != '0 && b_sh[0]) begin
      addend = {{WIDTH{1'b0}}, a_q} << idx;
    end
    sum = acc_q + addend;
    if (clr_i) begin
      acc_d = '0;
    end else if (cnt_i != '0) begin
      acc_d = sum;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      acc_q <= acc_d;
    end
  end

  assign sum_o = sum;

endmodule

// File: rtl/multi_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier controller: IDLE/CALC/FIN FSM, step
// counter for the downstream decoder, and the held product register.
module multi_seq_ctrl
  import multi_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [CNT_W-1:0]     cnt,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   P
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] sum;
  logic               accept;

  assign accept = (state_q == ST_IDLE) && START;

  // P captures the final sum on the CALC->FIN edge so it is valid with DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_CALC;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIN;
          cnt_d   = '0;
          p_d     = sum;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  multi_shift_add #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (CLK),
    .rst    (RST),
    .load_i (accept),
    .clr_i  (accept),
    .cnt_i  (cnt_q),
    .a_i    (A),
    .b_i    (B),
    .sum_o  (sum)
  );

  assign cnt  = cnt_q;
  assign BUSY = (state_q == ST_CALC);
  assign DONE = (state_q == ST_FIN);
  assign P    = p_q;

endmodule

// File: tb/tb_multi_seq_ctrl.sv
// Bench for multi_seq_ctrl: cycle model plus product scoreboard, checked on
// the falling clock edge.
module tb_multi_seq_ctrl;

  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic [W-1:0]   A, B;
  logic [2:0]     cnt;
  logic           BUSY, DONE;
  logic [2*W-1:0] P;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_st  = 0;
  int m_cnt = 0;
  int m_p   = 0;
  int m_cur = 0;
  int exp_q[$];

  multi_seq_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .cnt   (cnt),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .P     (P)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pushes the expected product when a START is accepted
  always @(posedge CLK) begin
    if (RST) begin
      m_st  <= 0;
      m_cnt <= 0;
      m_p   <= 0;
      exp_q.delete();
    end else begin
      case (m_st)
        0: if (START) begin
          exp_q.push_back(int'(A) * int'(B));
          m_cur <= int'(A) * int'(B);
          m_st  <= 1;
          m_cnt <= 1;
        end
        1: if (m_cnt == W) begin
          m_st  <= 2;
          m_cnt <= 0;
          m_p   <= m_cur;
        end else begin
          m_cnt <= m_cnt + 1;
        end
        default: m_st <= 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("busy", 32'(BUSY), 32'(m_st == 1));
      chk("done", 32'(DONE), 32'(m_st == 2));
      chk("p_hold", 32'(P), 32'(m_p));
      chk("cnt_range", 32'(cnt <= 3'(W)), 32'd1);
      chk("busy_done_excl", 32'(BUSY && DONE), 32'd0);
      if (DONE) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          chk("sb_p", 32'(P), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit chg);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    if (chg) begin
      A = '1; B = '1;
    end
    repeat (W + 2) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    RST = 1'b0;

    // directed latency: 3*5
    @(negedge CLK);
    A = 3; B = 5; START = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("lat_cnt", 32'(cnt), 32'(i));
    end
    @(negedge CLK);
    chk("lat_done", 32'(DONE), 32'd1);
    chk("lat_p", 32'(P), 32'd15);
    repeat (2) @(negedge CLK);

    op(15, 15, 1'b0);
    chk("p_225", 32'(P), 32'd225);
    op(0, 9, 1'b0);
    chk("p_0", 32'(P), 32'd0);

    // START held high across two operations
    @(negedge CLK);
    A = 2; B = 3; START = 1'b1;
    @(negedge CLK);
    A = 7; B = 7;
    repeat (W + 2) @(negedge CLK);
    START = 1'b0;
    repeat (W + 3) @(negedge CLK);
    chk("p_49", 32'(P), 32'd49);

    // inputs change after acceptance
    op(3, 5, 1'b1);
    chk("p_latched", 32'(P), 32'd15);

    // reset mid-CALC at cnt=2
    @(negedge CLK);
    A = 6; B = 7; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("abort_cnt2", 32'(cnt), 32'd2);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_cnt0", 32'(cnt), 32'd0);
    chk("abort_p0", 32'(P), 32'd0);
    chk("abort_idle", 32'(BUSY), 32'd0);
    RST = 1'b0;
    op(6, 7, 1'b0);
    chk("p_42", 32'(P), 32'd42);

    for (int k = 0; k < 8; k++) begin
      op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), k[0]);
    end

    repeat (2) @(negedge CLK);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
